// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: valid/ready word handshake between upstream FIFO/CSR
// logic and the UART transmitter.
//   in_valid : upstream has a word on in_data
//   in_ready : transmitter can accept (handshake = in_valid & in_ready)
//   in_data  : word to transmit, DATA_BITS wide
// master = upstream producer, slave = transmitter.
interface uart_tx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_BITS-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter with internal baud divider,
// optional odd/even parity and 1 or 2 stop bits. Data is sent LSB first.
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset
//   en    : gates acceptance of new frames only
//   in_if : valid/ready word handshake (slave side)
//   out   : serial tx line, idle high (registered)
//   busy  : frame in progress, START..STOP (registered)
//   done  : one-cycle pulse in the first IDLE cycle after a frame
module uart_tx_frame #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    uart_tx_frame_if.slave in_if,
    output logic           out,
    output logic           busy,
    output logic           done
);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_frame: DATA_BITS must be 5..9");
        end
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
        end
        if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity_mode
            $error("uart_tx_frame: PARITY_MODE must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_frame: STOP_BITS must be 1 or 2");
        end
    endgenerate

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam int CW = $clog2(CLKS_PER_BIT);
    // idx counts data bits and, reused, stop bits; DATA_BITS >= 5 keeps it >= 3 bits
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 wrap;
    logic                 accept;
    logic                 par_calc;

    assign in_if.in_ready = en && (state == IDLE);
    assign accept         = in_if.in_valid && in_if.in_ready;
    assign wrap           = (cnt == CNT_LAST);
    // even parity = XOR of data bits; odd is its inverse
    assign par_calc       = (PARITY_MODE == 1) ? ~(^in_if.in_data) : ^in_if.in_data;

    // out/busy are registered, so every transition loads the line value of
    // the state being entered; this puts the start bit on the handshake edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            out     <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE) begin
                cnt <= wrap ? '0 : cnt + CW'(1);
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg   <= in_if.in_data;
                        par_bit <= par_calc;
                        cnt     <= '0;
                        idx     <= '0;
                        out     <= 1'b0;
                        busy    <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    if (wrap) begin
                        out   <= shreg[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (wrap) begin
                        if (idx == IDX_LAST) begin
                            idx <= '0;
                            if (PARITY_MODE != 0) begin
                                out   <= par_bit;
                                state <= PARITY;
                            end else begin
                                out   <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            // shreg[0] is always the bit on the line
                            idx   <= idx + IW'(1);
                            shreg <= shreg >> 1;
                            out   <= shreg[1];
                        end
                    end
                end
                PARITY: begin
                    if (wrap) begin
                        out   <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (wrap) begin
                        if (idx == STOP_LAST) begin
                            idx   <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                default: begin
                    out   <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
